// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: pixel/line counters with horizontal and vertical phase FSMs.
// Every output is registered from the counter/FSM state of the previous cycle.
module dvi_timing_gen #(
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input  logic        clk_dvi,
  input  logic        rst,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 2048 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("dvi_timing_gen: illegal timing parameters");
  end

  // Last count of each phase; a phase ends on the cycle the counter sits on it.
  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_LAST  = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYN_LAST = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_FP_LAST  = 11'(V_ACTIVE + V_FP - 1);
  localparam logic [10:0] V_SYN_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYN, HS_BPO} h_state_e;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYN, VS_BPO} v_state_e;

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  h_state_e    h_state_q, h_state_d;
  v_state_e    v_state_q, v_state_d;
  logic [7:0]  frame_cnt_q;
  logic        de_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic [11:0] x_q;
  logic [10:0] y_q;

  logic h_wrap, v_wrap, at_origin;
  assign h_wrap    = (h_cnt_q == H_LAST);
  assign v_wrap    = (v_cnt_q == V_LAST);
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + 12'd1;
    v_cnt_d   = v_cnt_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 11'd1;

    case (h_state_q)
      HS_ACT:  if (h_cnt_q == H_ACT_LAST) h_state_d = HS_FP;
      HS_FP:   if (h_cnt_q == H_FP_LAST)  h_state_d = HS_SYN;
      HS_SYN:  if (h_cnt_q == H_SYN_LAST) h_state_d = HS_BPO;
      default: if (h_wrap)                h_state_d = HS_ACT;
    endcase

    // The vertical FSM only moves at the end of a line.
    if (h_wrap) begin
      case (v_state_q)
        VS_ACT:  if (v_cnt_q == V_ACT_LAST) v_state_d = VS_FP;
        VS_FP:   if (v_cnt_q == V_FP_LAST)  v_state_d = VS_SYN;
        VS_SYN:  if (v_cnt_q == V_SYN_LAST) v_state_d = VS_BPO;
        default: if (v_wrap)                v_state_d = VS_ACT;
      endcase
    end
  end

  always_ff @(posedge clk_dvi) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_state_q     <= HS_ACT;
      v_state_q     <= VS_ACT;
      frame_cnt_q   <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (!en) begin
      // Disabled: park at the raster origin and discard any partial frame; frame_cnt holds.
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_state_q     <= HS_ACT;
      v_state_q     <= VS_ACT;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      de_q          <= (h_state_q == HS_ACT) && (v_state_q == VS_ACT);
      hsync_q       <= (h_state_q == HS_SYN) ? HS_ON : ~HS_ON;
      vsync_q       <= (v_state_q == VS_SYN) ? VS_ON : ~VS_ON;
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= at_origin;
      if (at_origin) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: a 1080p instance for line timing, and two tiny-raster
// instances (14x7 totals) for frame, enable, wrap and polarity behaviour.
module tb_dvi_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: default 1080p parameters
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [11:0] x_a;
  logic [10:0] y_a;
  logic [7:0]  fc_a;
  // B: small raster H 8/2/2/2, V 4/1/1/1, positive syncs
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [11:0] x_b;
  logic [10:0] y_b;
  logic [7:0]  fc_b;
  // C: same small raster, negative syncs
  logic        rst_c = 1'b1, en_c = 1'b0;
  logic        hs_c, vs_c, de_c, ls_c, fs_c;
  logic [11:0] x_c;
  logic [10:0] y_c;
  logic [7:0]  fc_c;

  dvi_timing_gen u_dut_a (
    .clk_dvi(clk), .rst(rst_a), .en(en_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_b (
    .clk_dvi(clk), .rst(rst_b), .en(en_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) u_dut_c (
    .clk_dvi(clk), .rst(rst_c), .en(en_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } vec_t;

  vec_t vecs[7];

  int de_run, de_tot, hs_tot, hs_first, hs_last, vs_tot, ls_tot, fs_tot, pos_err, win_err;

  initial begin
    //            rst   en    de    hs    vs    x       y       ls    fs    fc
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 11'd0, 1'b1, 1'b1, 8'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 11'd0, 1'b0, 1'b0, 8'd1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 8'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 11'd0, 1'b1, 1'b1, 8'd2};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 11'd0, 1'b0, 1'b0, 8'd2};

    tick();
    tick();

    // Reset, rst-over-en priority, start-up latency and a one-cycle en drop on B.
    for (int i = 0; i < 7; i++) begin
      rst_b = vecs[i].rst;
      en_b  = vecs[i].en;
      tick();
      check($sformatf("vec%0d.de", i), 32'(de_b), 32'(vecs[i].de));
      check($sformatf("vec%0d.hsync", i), 32'(hs_b), 32'(vecs[i].hs));
      check($sformatf("vec%0d.vsync", i), 32'(vs_b), 32'(vecs[i].vs));
      check($sformatf("vec%0d.x", i), 32'(x_b), 32'(vecs[i].x));
      check($sformatf("vec%0d.y", i), 32'(y_b), 32'(vecs[i].y));
      check($sformatf("vec%0d.line_start", i), 32'(ls_b), 32'(vecs[i].ls));
      check($sformatf("vec%0d.frame_start", i), 32'(fs_b), 32'(vecs[i].fs));
      check($sformatf("vec%0d.frame_cnt", i), 32'(fc_b), 32'(vecs[i].fc));
    end

    // 1080p: reset release with en=1, then one full line.
    en_a = 1'b1;
    tick();
    check("a.rst_priority.frame_start", 32'(fs_a), 32'd0);
    rst_a = 1'b0;
    tick();
    check("a.first.frame_start", 32'(fs_a), 32'd1);
    check("a.first.de", 32'(de_a), 32'd1);
    check("a.first.frame_cnt", 32'(fc_a), 32'd1);
    de_run = -1; de_tot = 0; hs_tot = 0; hs_first = -1; hs_last = -1;
    vs_tot = 0; ls_tot = 0; pos_err = 0;
    for (int i = 0; i < 2200; i++) begin
      if (i > 0) tick();
      if (de_a) de_tot++;
      else if (de_run < 0) de_run = i;
      if (hs_a) begin
        hs_tot++;
        if (hs_first < 0) hs_first = int'(x_a);
        hs_last = int'(x_a);
      end
      if (vs_a) vs_tot++;
      if (ls_a) ls_tot++;
      if (int'(x_a) != i || y_a != 11'd0) pos_err++;
    end
    check("a.de_first_low_x", 32'(de_run), 32'd1920);
    check("a.de_cycles_per_line", 32'(de_tot), 32'd1920);
    check("a.hsync_cycles", 32'(hs_tot), 32'd44);
    check("a.hsync_first_x", 32'(hs_first), 32'd2008);
    check("a.hsync_last_x", 32'(hs_last), 32'd2051);
    check("a.vsync_cycles_line0", 32'(vs_tot), 32'd0);
    check("a.line_start_count", 32'(ls_tot), 32'd1);
    check("a.xy_sequence_errors", 32'(pos_err), 32'd0);
    tick();
    check("a.line2.line_start", 32'(ls_a), 32'd1);
    check("a.line2.x", 32'(x_a), 32'd0);
    check("a.line2.y", 32'(y_a), 32'd1);
    check("a.line2.de", 32'(de_a), 32'd1);

    // Small raster: one full frame of 14x7 = 98 cycles.
    rst_b = 1'b1;
    en_b  = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    de_tot = 0; hs_tot = 0; vs_tot = 0; ls_tot = 0; fs_tot = 0; pos_err = 0; win_err = 0;
    for (int i = 0; i < 98; i++) begin
      if (i > 0) tick();
      if (de_b) de_tot++;
      if (hs_b) hs_tot++;
      if (vs_b) vs_tot++;
      if (ls_b) ls_tot++;
      if (fs_b) fs_tot++;
      if (int'(x_b) != i % 14 || int'(y_b) != i / 14) pos_err++;
      if (de_b != (x_b < 12'd8 && y_b < 11'd4)) win_err++;
      if (hs_b != (x_b == 12'd10 || x_b == 12'd11)) win_err++;
      if (vs_b != (y_b == 11'd5)) win_err++;
    end
    check("b.de_cycles_per_frame", 32'(de_tot), 32'd32);
    check("b.hsync_cycles_per_frame", 32'(hs_tot), 32'd14);
    check("b.vsync_cycles_per_frame", 32'(vs_tot), 32'd14);
    check("b.line_start_count", 32'(ls_tot), 32'd7);
    check("b.frame_start_count", 32'(fs_tot), 32'd1);
    check("b.xy_sequence_errors", 32'(pos_err), 32'd0);
    check("b.window_errors", 32'(win_err), 32'd0);
    tick();
    check("b.frame2.frame_start", 32'(fs_b), 32'd1);
    check("b.frame2.x", 32'(x_b), 32'd0);
    check("b.frame2.y", 32'(y_b), 32'd0);
    check("b.frame2.frame_cnt", 32'(fc_b), 32'd2);

    // Drop en mid-frame at x=5, y=2, then re-enable.
    for (int k = 0; k < 33; k++) tick();
    check("b.middrop.x_before", 32'(x_b), 32'd5);
    check("b.middrop.y_before", 32'(y_b), 32'd2);
    en_b = 1'b0;
    tick();
    check("b.middrop.de", 32'(de_b), 32'd0);
    check("b.middrop.x", 32'(x_b), 32'd0);
    check("b.middrop.y", 32'(y_b), 32'd0);
    check("b.middrop.line_start", 32'(ls_b), 32'd0);
    check("b.middrop.frame_cnt_hold", 32'(fc_b), 32'd2);
    tick();
    tick();
    check("b.disabled.idle", {de_b, hs_b, vs_b, ls_b, fs_b, x_b, y_b}, 32'd0);
    en_b = 1'b1;
    tick();
    check("b.reenable.frame_start", 32'(fs_b), 32'd1);
    check("b.reenable.de", 32'(de_b), 32'd1);
    check("b.reenable.xy", {x_b, y_b}, 32'd0);
    check("b.reenable.frame_cnt", 32'(fc_b), 32'd3);

    // frame_cnt wrap over 256 frames.
    rst_b = 1'b1;
    tick();
    check("b.wrap.reset_frame_cnt", 32'(fc_b), 32'd0);
    rst_b = 1'b0;
    tick();
    check("b.wrap.first_frame_cnt", 32'(fc_b), 32'd1);
    fs_tot = 0;
    for (int k = 0; k < 254 * 98; k++) begin
      tick();
      if (fs_b) fs_tot++;
    end
    check("b.wrap.frame_starts_seen", 32'(fs_tot), 32'd254);
    check("b.wrap.frame_cnt_255", 32'(fc_b), 32'd255);
    for (int k = 0; k < 98; k++) tick();
    check("b.wrap.frame_start", 32'(fs_b), 32'd1);
    check("b.wrap.frame_cnt_0", 32'(fc_b), 32'd0);

    // Negative sync polarity on C.
    check("c.reset.hsync_idle_high", 32'(hs_c), 32'd1);
    check("c.reset.vsync_idle_high", 32'(vs_c), 32'd1);
    rst_c = 1'b0;
    tick();
    check("c.disabled.syncs_high", {hs_c, vs_c, de_c}, 32'd6);
    en_c = 1'b1;
    tick();
    check("c.first.frame_start", 32'(fs_c), 32'd1);
    check("c.first.frame_cnt", 32'(fc_c), 32'd1);
    hs_tot = 0; vs_tot = 0; de_tot = 0; ls_tot = 0; win_err = 0;
    for (int i = 0; i < 98; i++) begin
      if (i > 0) tick();
      if (!hs_c) hs_tot++;
      if (!vs_c) vs_tot++;
      if (de_c) de_tot++;
      if (ls_c) ls_tot++;
      if (hs_c == (x_c == 12'd10 || x_c == 12'd11)) win_err++;
      if (vs_c == (y_c == 11'd5)) win_err++;
    end
    check("c.hsync_low_cycles", 32'(hs_tot), 32'd14);
    check("c.vsync_low_cycles", 32'(vs_tot), 32'd14);
    check("c.de_cycles", 32'(de_tot), 32'd32);
    check("c.line_start_count", 32'(ls_tot), 32'd7);
    check("c.sync_window_errors", 32'(win_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1920: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 88: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 44: hsync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 148: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 1080: active lines per frame.
REQ-006 SHALL have parameter V_FP, default 4: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 5: vsync width, in lines.
REQ-008 SHALL have parameter V_BP, default 36: vertical back porch, in lines.
REQ-009 SHALL have parameter HSYNC_POL, default 1: active level of hsync.
REQ-010 SHALL have parameter VSYNC_POL, default 1: active level of vsync.
REQ-011 SHALL have port clk_dvi, input, 1 bit: the single pixel clock (148.5 MHz); all logic is on its rising edge.
REQ-012 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-013 SHALL have port en, input, 1 bit: run enable, typically driven from mmcm_locked after synchronisation.
REQ-014 SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-015 SHALL have port vsync, output, 1 bit: vertical sync.
REQ-016 SHALL have port de, output, 1 bit: data enable (active video).
REQ-017 SHALL have port x, output, 12 bits: horizontal position.
REQ-018 SHALL have port y, output, 11 bits: vertical position.
REQ-019 SHALL have port line_start, output, 1 bit: single-cycle pulse at the first pixel of each line.
REQ-020 SHALL have port frame_start, output, 1 bit: single-cycle pulse at the first pixel of each frame.
REQ-021 SHALL have port frame_cnt, output, 8 bits: count of frames started.

Function
REQ-022 SHALL compute H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (2200) and V_TOTAL likewise (1125).
REQ-023 SHALL fail elaboration if H_TOTAL > 4096, V_TOTAL > 2048, or any parameter is < 1.
REQ-024 SHALL keep h_cnt in 0..H_TOTAL-1, incrementing every cycle while en=1 and wrapping to 0.
REQ-025 SHALL increment v_cnt only on an h_cnt wrap, over 0..V_TOTAL-1, wrapping to 0.
REQ-026 SHALL track horizontal phase with an FSM: H_ACT (h<H_ACTIVE) -> H_FP -> H_SYN -> H_BPO -> H_ACT.
REQ-027 SHALL make each FSM transition on the cycle h_cnt crosses the corresponding boundary.
REQ-028 SHALL use a vertical FSM V_ACT/V_FP/V_SYN/V_BPO with identical structure, advancing only on h_cnt wrap.
REQ-029 SHALL register all outputs, so each output at cycle n reflects the counter/FSM state at cycle n-1 (latency 1).
REQ-030 SHALL drive de=1 iff h state is H_ACT and v state is V_ACT.
REQ-031 SHALL drive hsync=HSYNC_POL iff h state is H_SYN (h_cnt 2008..2051), else ~HSYNC_POL.
REQ-032 SHALL drive vsync=VSYNC_POL iff v state is V_SYN (v_cnt 1084..1088, entire lines), else ~VSYNC_POL.
REQ-033 SHALL drive x=h_cnt and y=v_cnt in all phases, including blanking.
REQ-034 SHALL pulse line_start=1 for one cycle when h_cnt=0.
REQ-035 SHALL pulse frame_start=1 for one cycle when h_cnt=0 and v_cnt=0.
REQ-036 SHALL increment frame_cnt on each frame_start, wrapping 255 -> 0.
REQ-037 SHALL, while en=0, hold h_cnt=v_cnt=0, FSMs in H_ACT/V_ACT, and drive all outputs idle (de=0, syncs inactive, pulses 0, x=y=0); frame_cnt SHALL hold.
REQ-038 SHALL, on en 0->1, present x=0, y=0, de=1, frame_start=1 on the cycle after the first en=1 edge.
REQ-039 SHALL, on en deasserted mid-frame, make the outputs idle on the next edge; the partial frame is discarded.
REQ-040 SHALL produce identical behaviour for any legal parameter set; nothing is hard-coded to 1080p.

Reset
REQ-041 SHALL, with rst=1 at an edge, clear h_cnt, v_cnt, FSMs, frame_cnt=0, de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, x=0, y=0, line_start=0, frame_start=0.
REQ-042 SHALL give rst priority over en; deassertion with en=1 behaves as REQ-038.

Verification
REQ-043 SHALL cover: reset release with en=1 -> next cycle frame_start=1, de=1, x=0, y=0; de stays high 1920 consecutive cycles, then 280 cycles low.
REQ-044 SHALL cover: free run one line -> hsync high for exactly 44 cycles with x=2008..2051; line_start period 2200 cycles.
REQ-045 SHALL cover: free run one frame -> vsync high for 5x2200 cycles with y=1084..1088; frame_start period 2,475,000 cycles; de asserted 1920x1080 cycles per frame.
REQ-046 SHALL cover: en dropped at x=100, y=500 -> next cycle de=0 and x=y=0; re-enable -> frame_start one cycle later, frame_cnt incremented by 1.
REQ-047 SHALL cover: 256 frames with small parameters (H 8/2/2/2, V 4/1/1/1) -> frame_cnt wraps 255 -> 0.
REQ-048 SHALL cover: HSYNC_POL=0, VSYNC_POL=0 -> syncs idle high and low only in the sync windows.
